// File: rtl/dcache_pkg.sv
// dcache_pkg: shared FSM state type, way count and derived-width helper
// for the two-way set-associative data cache.
package dcache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MISS,
        ST_WRITEBACK,
        ST_REFILL,
        ST_REFILL_DONE
    } state_e;

    localparam int NUM_WAYS = 2;

    // Tag width left over once the set index and line offset are removed.
    function automatic int tag_width(input int addr_w, input int line_bytes, input int sets);
        return addr_w - $clog2(sets) - $clog2(line_bytes);
    endfunction

endpackage

// File: rtl/dcache_way_array.sv
// dcache_way_array: storage for one cache way (tag, line data, valid, dirty).
// Reads are asynchronous at idx_i; writes take effect on the clock edge.
module dcache_way_array
    import dcache_pkg::*;
#(
    parameter int SETS   = 16,
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 23,
    parameter int LINE_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic              we_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [LINE_W-1:0] line_i,
    input  logic              dirty_set_i,
    input  logic              dirty_clr_i,
    output logic              valid_o,
    output logic              dirty_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [LINE_W-1:0] line_o
);

    logic [SETS-1:0]   valid_q, valid_d;
    logic [SETS-1:0]   dirty_q, dirty_d;
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [LINE_W-1:0] line_mem [SETS];

    // Next-state of the per-set valid and dirty bits.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (we_i)        valid_d[idx_i] = 1'b1;
        if (dirty_clr_i) dirty_d[idx_i] = 1'b0;
        if (dirty_set_i) dirty_d[idx_i] = 1'b1;
    end

    // Valid and dirty flags: these must come out of reset cleared.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            // NOTE: state in clocked blocks uses <= so all flops see pre-edge values.
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and line storage, written on a refill or a write hit.
    always_ff @(posedge clk_i) begin
        // NOTE: the arrays have no reset; valid_q gates every use, so they can map to RAM.
        if (we_i) begin
            tag_mem[idx_i]  <= tag_i;
            line_mem[idx_i] <= line_i;
        end
    end

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_mem[idx_i];
    assign line_o  = line_mem[idx_i];

endmodule

// File: rtl/dcache_2way_sa.sv
// dcache_2way_sa: two-way set-associative, write-back, write-allocate data
// cache. Stall-based single-word CPU port; line-wide enable/ack memory port.
// Optional hit/miss counters are built when DCACHE_PERF_CNT_EN is defined.
module dcache_2way_sa
    import dcache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int WORD_W     = 32,
    parameter int LINE_BYTES = 32,
    parameter int SETS       = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_W-1:0]     p1_addr_i,
    input  logic [WORD_W-1:0]     p1_data_i,
    input  logic                  p1_MemRead_i,
    input  logic                  p1_MemWrite_i,
    output logic [WORD_W-1:0]     p1_data_o,
    output logic                  p1_stall_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [8*LINE_BYTES-1:0] mem_data_o,
    input  logic [8*LINE_BYTES-1:0] mem_data_i,
    output logic                  mem_enable_o,
    output logic                  mem_write_o,
    input  logic                  mem_ack_i,
    output logic [31:0]           hit_cnt_o,
    output logic [31:0]           miss_cnt_o
);

    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = tag_width(ADDR_W, LINE_BYTES, SETS);
    localparam int LINE_W = 8 * LINE_BYTES;
    localparam int BOFF_W = $clog2(WORD_W / 8);

    // Request decode.
    logic              req;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  word_sel;

    assign req      = p1_MemRead_i | p1_MemWrite_i;
    assign req_tag  = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign req_idx  = p1_addr_i[OFF_W +: IDX_W];
    assign word_sel = p1_addr_i[OFF_W-1:0] >> BOFF_W;

    // Controller state.
    state_e             state_q;
    logic               victim_q;
    logic [IDX_W-1:0]   idx_q;
    logic [TAG_W-1:0]   tag_q;
    logic               mem_enable_q;
    logic               mem_write_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [LINE_W-1:0]  mem_data_q;
    logic [SETS-1:0]    lru_q, lru_d;

    // Way array interface.
    logic [NUM_WAYS-1:0] way_valid, way_dirty, way_hit, way_we, way_dset, way_dclr;
    logic [TAG_W-1:0]    way_tag  [NUM_WAYS];
    logic [LINE_W-1:0]   way_line [NUM_WAYS];
    logic [IDX_W-1:0]    arr_idx;
    logic [TAG_W-1:0]    arr_tag;
    logic [LINE_W-1:0]   arr_line;

    logic              is_idle, hit_any, hit_way, access_hit, write_hit, refill_fire, victim_sel;
    logic [LINE_W-1:0] hit_line, merged_line;

    assign is_idle     = (state_q == ST_IDLE);
    assign hit_any     = |way_hit;
    assign hit_way     = way_hit[1];
    assign hit_line    = way_line[hit_way];
    assign access_hit  = is_idle & req & hit_any;
    assign write_hit   = is_idle & p1_MemWrite_i & hit_any;
    assign refill_fire = (state_q == ST_REFILL) & mem_ack_i;

    // Outside IDLE the arrays look at the latched miss set, so a dropped or
    // changed request cannot redirect an in-flight refill.
    assign arr_idx  = is_idle ? req_idx : idx_q;
    assign arr_tag  = refill_fire ? tag_q : req_tag;
    assign arr_line = refill_fire ? mem_data_i : merged_line;

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        assign way_hit[w]  = way_valid[w] & (way_tag[w] == req_tag);
        assign way_we[w]   = (write_hit & way_hit[w]) | (refill_fire & (victim_q == 1'(w)));
        assign way_dset[w] = write_hit & way_hit[w];
        assign way_dclr[w] = refill_fire & (victim_q == 1'(w));

        dcache_way_array #(
            .SETS   (SETS),
            .IDX_W  (IDX_W),
            .TAG_W  (TAG_W),
            .LINE_W (LINE_W)
        ) u_way (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .idx_i       (arr_idx),
            .we_i        (way_we[w]),
            .tag_i       (arr_tag),
            .line_i      (arr_line),
            .dirty_set_i (way_dset[w]),
            .dirty_clr_i (way_dclr[w]),
            .valid_o     (way_valid[w]),
            .dirty_o     (way_dirty[w]),
            .tag_o       (way_tag[w]),
            .line_o      (way_line[w])
        );
    end

    // Hit line with the CPU write word merged in at the requested offset.
    always_comb begin
        merged_line = hit_line;
        merged_line[word_sel*WORD_W +: WORD_W] = p1_data_i;
    end

    // Victim: first invalid way (way 0 preferred), else the LRU way.
    always_comb begin
        if (!way_valid[0])      victim_sel = 1'b0;
        else if (!way_valid[1]) victim_sel = 1'b1;
        else                    victim_sel = lru_q[req_idx];
    end

    // LRU bit per set names the way to evict next; any access points it away.
    always_comb begin
        lru_d = lru_q;
        if (access_hit)  lru_d[req_idx] = ~hit_way;
        if (refill_fire) lru_d[idx_q]   = ~victim_q;
    end

    // LRU state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) lru_q <= '0;
        else        lru_q <= lru_d;
    end

    // Miss-handling FSM with registered memory-side outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            victim_q     <= 1'b0;
            idx_q        <= '0;
            tag_q        <= '0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req && !hit_any) begin
                        state_q  <= ST_MISS;
                        victim_q <= victim_sel;
                        idx_q    <= req_idx;
                        tag_q    <= req_tag;
                    end
                end
                ST_MISS: begin
                    mem_enable_q <= 1'b1;
                    if (way_valid[victim_q] && way_dirty[victim_q]) begin
                        mem_write_q <= 1'b1;
                        mem_addr_q  <= {way_tag[victim_q], idx_q, {OFF_W{1'b0}}};
                        mem_data_q  <= way_line[victim_q];
                        state_q     <= ST_WRITEBACK;
                    end else begin
                        mem_write_q <= 1'b0;
                        mem_addr_q  <= {tag_q, idx_q, {OFF_W{1'b0}}};
                        state_q     <= ST_REFILL;
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ack_i) begin
                        mem_write_q <= 1'b0;
                        mem_addr_q  <= {tag_q, idx_q, {OFF_W{1'b0}}};
                        state_q     <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (mem_ack_i) begin
                        mem_enable_q <= 1'b0;
                        state_q      <= ST_REFILL_DONE;
                    end
                end
                ST_REFILL_DONE: state_q <= ST_IDLE;
                default:        state_q <= ST_IDLE;
            endcase
        end
    end

    // A lookup only completes in IDLE, which keeps the CPU stalled through
    // REFILL_DONE even though the installed line already matches there.
    assign p1_stall_o   = req & ~(hit_any & is_idle);
    assign p1_data_o    = hit_line[word_sel*WORD_W +: WORD_W];
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    // Counter next-state: completed lookups and IDLE->MISS transitions.
    always_comb begin
        hit_cnt_d  = hit_cnt_q + 32'(access_hit);
        miss_cnt_d = miss_cnt_q + 32'(is_idle & req & ~hit_any);
    end

    // Performance counter registers, wrapping modulo 2^32.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif

endmodule

// File: doc/dcache_2way_sa.md
Name: dcache_2way_sa

Overview:
Parametrised two-way set-associative, write-back, write-allocate data cache between the CPU MEM stage and the line-wide data memory.
- Successor to the direct-mapped dcache: adds configurable sets and line size, per-set LRU replacement and a latched victim way.
- CPU side: single-word, stall-based. Memory side: enable/ack, one full line per transfer.

Parameters:
ADDR_W, 32, address width
WORD_W, 32, CPU data width
LINE_BYTES, 32, bytes per line (power of 2, at least WORD_W/8)
SETS, 16, number of sets (power of 2)
Derived: OFF_W=log2(LINE_BYTES), IDX_W=log2(SETS), TAG_W=ADDR_W-IDX_W-OFF_W, LINE_W=8*LINE_BYTES

Ports:
clk_i  in  1  clock
rst_i  in  1  async active-low reset
p1_addr_i  in  ADDR_W  byte address, word aligned
p1_data_i  in  WORD_W  write data
p1_MemRead_i  in  1  read request
p1_MemWrite_i  in  1  write request
p1_data_o  out  WORD_W  read data
p1_stall_o  out  1  request not yet serviced
mem_addr_o  out  ADDR_W  line address, low OFF_W bits zero
mem_data_o  out  LINE_W  writeback line
mem_data_i  in  LINE_W  refill line
mem_enable_o  out  1  memory request
mem_write_o  out  1  1 = writeback, 0 = refill
mem_ack_i  in  1  transfer complete, one-cycle pulse
hit_cnt_o  out  32  hits (optional feature)
miss_cnt_o  out  32  misses (optional feature)

Behaviour:
- Reset (async): state IDLE; all valid, dirty and LRU bits 0; mem_enable_o=0, mem_write_o=0; counters 0. Tag and data arrays are not reset.
- Outputs during reset follow from that state: p1_stall_o=req with no hit, since all lines are invalid.
- Lookup: hit_w = valid[w] & tag[w]==addr tag. Hit is combinational, zero stall.
- p1_stall_o = (MemRead|MemWrite) & ~hit. MemRead and MemWrite are never both high.
- Read hit: p1_data_o = hit-way word at offset. p1_data_o is undefined when there is no hit.
- Write hit: on clk edge, the word is merged into the line, dirty=1, and LRU points to the other way.
- Read hit also updates LRU on the edge.
- Victim selection: first invalid way, way 0 preferred; otherwise the LRU way. Selected in IDLE on miss, then latched.
- FSM states:
  - IDLE: req & ~hit -> MISS, latching the victim way.
  - MISS: victim valid&dirty -> WRITEBACK, with enable=1, write=1 and addr={victim tag, idx, 0}. Otherwise -> REFILL, with enable=1, write=0 and addr={req tag, idx, 0}.
  - WRITEBACK: hold everything until ack. On ack: write=0, enable stays 1, addr switches to the refill address, -> REFILL.
  - REFILL: hold until ack. On ack: enable=0, line/tag written to the victim way, valid=1, dirty=0, LRU points to the other way, -> REFILL_DONE.
  - REFILL_DONE: -> IDLE. The lookup now hits; a write miss then completes as a write hit.
- Clean miss timing: stall from cycle 0; enable rises at cycle 2; ack at cycle 2+L; stall low at cycle 4+L.
- Dirty miss adds the writeback latency.
- mem_addr_o, mem_data_o and mem_write_o are stable while mem_enable_o=1.
- mem_ack_i is ignored in IDLE, MISS and REFILL_DONE.
- The CPU holds addr, data and request stable while stalled; changing them is unsupported.
- Request dropped mid-miss: the transfer completes and the line is installed.
- Reset mid-transfer: aborts immediately and enable drops. The memory model must tolerate an abandoned request.

Optional Feature:
DCACHE_PERF_CNT_EN
- Defined: hit_cnt_o increments on each IDLE cycle with req&hit; miss_cnt_o increments on each IDLE->MISS transition. Both are 32-bit and wrap modulo 2^32.
- Undefined: both outputs are tied to 0 and no counter flops are generated.

Decomposition:
- Package dcache_pkg: FSM state enum (IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE) and the derived width function/localparams.
- One natural sub-module: dcache_way_array, one instance per way. Holds tag/valid/dirty/data storage; ports are index, write enable, tag in/out, line in/out, plus dirty set/clear.
- LRU bits, victim latch and FSM live in the top module.

Test Plan:
- Cold read 0x0000_0040 with memory latency 3 -> 1 refill at 0x40, stall 7 cycles, returned word matches memory; re-read hits with 0 stall.
- Read 0x000, then 0x200 (same set, SETS=16, LINE_BYTES=32) -> the two lines occupy way0 and way1; both hit afterwards; no writeback.
- Write hit 0x200 with 0xDEADBEEF, read 0x000, read 0x400 -> way1 (LRU, holding 0x200) is evicted, writeback at 0x200 carries 0xDEADBEEF, then refill at 0x400.
- Write miss 0x800 with 0x12345678 -> refill, then word merged and dirty=1; a later forced eviction writes back 0x12345678.
- Reset asserted during REFILL -> mem_enable_o=0 that cycle, all lines invalid, next access misses.
- With DCACHE_PERF_CNT_EN, run the scenario-2 sequence -> miss_cnt_o=2, hit_cnt_o equals the number of repeated reads.
